// File: rtl/fft64_strm_out_if.sv
// Output stream bundle of the FFT64 output stage: FWFT sample stream with framing flags.
// master drives the samples, slave provides OREADY.
interface fft64_strm_out_if #(
    parameter int nb = 16
);
    logic          OVALID;
    logic          OREADY;
    logic [nb-1:0] OR;
    logic [nb-1:0] OI;
    logic [5:0]    OIDX;
    logic          OSOF;
    logic          OEOF;

    modport master (output OVALID, OR, OI, OIDX, OSOF, OEOF, input OREADY);
    modport slave  (input OVALID, OR, OI, OIDX, OSOF, OEOF, output OREADY);
endinterface

// File: rtl/fft64_strm_out.sv
// FFT64 output stage: tags upstream samples with a 64-point frame index and buffers them in a FWFT FIFO.
// Optional sticky overflow flag OVF is built when FFT64_OVF_DET_EN is defined.
module fft64_strm_out #(
    parameter int nb      = 16,
    parameter int FIFO_AW = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          RDY,
    input  logic [nb-1:0] DR,
    input  logic [nb-1:0] DI,
    output logic          ED_REQ,
`ifdef FFT64_OVF_DET_EN
    output logic          OVF,
`endif
    fft64_strm_out_if.master o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_REQ   = (FIFO_AW + 1)'(DEPTH - 3);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [nb-1:0] re;
        logic [nb-1:0] im;
        logic [5:0]    idx;
        logic          sof;
        logic          eof;
    } entry_t;

    state_t             state;
    logic [5:0]         idx;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    entry_t             mem [DEPTH];
    entry_t             head;

    logic capture;
    logic empty;
    logic full;
    logic pop;
    logic push;

    // The RDY cycle only arms the indexer; it never stores a sample itself.
    assign capture = ED & ~RDY & (state == RUN);
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = ~empty & o.OREADY;
    assign push    = capture & (~full | pop);

    // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ED_REQ <= 1'b1;
        end else begin
            if (RDY) begin
                state <= RUN;
                idx   <= '0;
            end else if (capture) begin
                idx <= idx + 6'd1;   // advances even when the sample is dropped
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count_next;
            ED_REQ <= (count_next <= CNT_REQ);
        end
    end

    // NOTE: the storage array is not reset; pointers and count define validity, stale words are never shown.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= '{re: DR, im: DI, idx: idx, sof: (idx == 6'd0), eof: (idx == 6'd63)};
    end

`ifdef FFT64_OVF_DET_EN
    always_ff @(posedge CLK) begin
        if (RST)
            OVF <= 1'b0;
        else if (capture && !push)
            OVF <= 1'b1;
    end
`endif

    assign head     = mem[rd_ptr];
    assign o.OVALID = ~empty;
    assign o.OR     = empty ? '0 : head.re;
    assign o.OI     = empty ? '0 : head.im;
    assign o.OIDX   = empty ? '0 : head.idx;
    assign o.OSOF   = ~empty & head.sof;
    assign o.OEOF   = ~empty & head.eof;
endmodule

// File: tb/tb_fft64_strm_out.sv
// Self-checking bench for fft64_strm_out: queue-based frame/FIFO model plus directed scenarios.
// Build with +define+FFT64_OVF_DET_EN to also check the sticky OVF flag.
module tb_fft64_strm_out;
    localparam int NB = 16;
    localparam int OW = 2 * NB + 11;

    typedef struct packed {
        logic [NB-1:0] re;
        logic [NB-1:0] im;
        logic [5:0]    idx;
        logic          sof;
        logic          eof;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ED;
    logic          RDY;
    logic [NB-1:0] DR;
    logic [NB-1:0] DI;
    logic          ED_REQ;
    logic          ovf_obs;
`ifdef FFT64_OVF_DET_EN
    logic          OVF;
    assign ovf_obs = OVF;
`else
    assign ovf_obs = 1'b0;
`endif

    fft64_strm_out_if #(.nb(NB)) bus ();

    fft64_strm_out #(.nb(NB), .FIFO_AW(3)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ED     (ED),
        .RDY    (RDY),
        .DR     (DR),
        .DI     (DI),
        .ED_REQ (ED_REQ),
`ifdef FFT64_OVF_DET_EN
        .OVF    (OVF),
`endif
        .o      (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: frame position counter and a bounded queue of tagged samples.
    ent_t q[$];
    bit   m_run   = 1'b0;
    int   m_pos   = 0;
    bit   m_edreq = 1'b1;
    bit   m_ovf   = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    logic [OW-1:0] obs;
    assign obs = {ED_REQ, ovf_obs, bus.OVALID, bus.OR, bus.OI, bus.OIDX, bus.OSOF, bus.OEOF};

    function automatic logic [OW-1:0] exp_vec();
        logic ovf_e;
`ifdef FFT64_OVF_DET_EN
        ovf_e = m_ovf;
`else
        ovf_e = 1'b0;
`endif
        if (q.size() == 0)
            return {m_edreq, ovf_e, 1'b0, {(2 * NB + 8){1'b0}}};
        return {m_edreq, ovf_e, 1'b1, q[0].re, q[0].im, q[0].idx, q[0].sof, q[0].eof};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
    task automatic tick(input bit rst, input bit rdy, input bit ed,
                        input logic [NB-1:0] dr, input logic [NB-1:0] di, input bit oready);
        bit pop;
        bit cap;
        RST = rst; RDY = rdy; ED = ed; DR = dr; DI = di; bus.OREADY = oready;
        @(posedge CLK);
        if (rst) begin
            q.delete();
            m_run = 1'b0; m_pos = 0; m_edreq = 1'b1; m_ovf = 1'b0;
        end else begin
            pop = (q.size() != 0) && oready;
            cap = ed && !rdy && m_run;
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < 8)
                    q.push_back('{re: dr, im: di, idx: 6'(m_pos), sof: (m_pos == 0), eof: (m_pos == 63)});
                else
                    m_ovf = 1'b1;
                m_pos = (m_pos + 1) % 64;
            end
            if (rdy) begin
                m_run = 1'b1;
                m_pos = 0;
            end
            m_edreq = (q.size() <= 5);
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, '0, '0, 0);
        tick(1, 1, 1, 16'h1234, 16'h5678, 1);
        n_total++;
        if (obs !== {1'b1, 1'b0, 1'b0, {(2 * NB + 8){1'b0}}})
            $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, {(2 * NB + 8){1'b0}}});
        else n_pass++;
    endtask

    task automatic test_no_rdy();
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 1, 16'($urandom), 16'($urandom), 1);
            n_total++;
            if (bus.OVALID !== 1'b0 || ED_REQ !== 1'b1)
                $display("FAIL no_rdy_idle i=%0d: got ovalid=%b ed_req=%b expected ovalid=0 ed_req=1",
                         i, bus.OVALID, ED_REQ);
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        logic [2*NB+8:0] want;
        tick(1, 0, 0, '0, '0, 1);
        tick(0, 1, 0, '0, '0, 1);
        for (int n = 0; n < 64; n++) begin
            tick(0, 0, 1, 16'(n), 16'(-n), 1);
            want = {1'b1, 16'(n), 16'(-n), 6'(n), (n == 0), (n == 63)};
            n_total++;
            if (obs[2*NB+8:0] !== want)
                $display("FAIL frame_sample n=%0d: got %h expected %h", n, obs[2*NB+8:0], want);
            else n_pass++;
        end
        tick(0, 0, 0, '0, '0, 1);
        n_total++;
        if (obs !== exp_vec() || bus.OVALID !== 1'b0)
            $display("FAIL frame_drain: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_wrap();
        tick(1, 0, 0, '0, '0, 1);
        tick(0, 1, 0, '0, '0, 1);
        for (int c = 0; c < 130; c++) begin
            tick(0, 0, 1, 16'($urandom), 16'($urandom), 1);
            n_total++;
            if (obs !== exp_vec())
                $display("FAIL wrap_model c=%0d: got %h expected %h", c, obs, exp_vec());
            else n_pass++;
            if (c == 64 || c == 128 || c == 63) begin
                n_total++;
                if (bus.OIDX !== 6'(c % 64) || bus.OSOF !== (c != 63) || bus.OEOF !== (c == 63))
                    $display("FAIL wrap_boundary c=%0d: got idx=%0d sof=%b eof=%b expected idx=%0d",
                             c, bus.OIDX, bus.OSOF, bus.OEOF, c % 64);
                else n_pass++;
            end
        end
        tick(0, 0, 0, '0, '0, 1);
    endtask

    task automatic test_overflow();
        int seen;
        int last;
        tick(1, 0, 0, '0, '0, 0);
        tick(0, 1, 0, '0, '0, 0);
        for (int c = 1; c <= 9; c++) begin
            tick(0, 0, 1, 16'($urandom), 16'($urandom), 0);
            n_total++;
            if (obs !== exp_vec())
                $display("FAIL ovf_fill c=%0d: got %h expected %h", c, obs, exp_vec());
            else n_pass++;
            if (c == 5 || c == 6) begin
                n_total++;
                if (ED_REQ !== (c == 5))
                    $display("FAIL ovf_ed_req c=%0d: got %b expected %b", c, ED_REQ, (c == 5));
                else n_pass++;
            end
        end
        n_total++;
        if (bus.OVALID !== 1'b1 || bus.OIDX !== 6'd0)
            $display("FAIL ovf_head: got ovalid=%b idx=%0d expected ovalid=1 idx=0", bus.OVALID, bus.OIDX);
        else n_pass++;
`ifdef FFT64_OVF_DET_EN
        n_total++;
        if (OVF !== 1'b1)
            $display("FAIL ovf_flag: got %b expected 1", OVF);
        else n_pass++;
`endif
        seen = 0;
        last = -1;
        for (int d = 0; d < 10; d++) begin
            if (bus.OVALID === 1'b1) begin
                seen++;
                last = int'(bus.OIDX);
            end
            tick(0, 0, 0, '0, '0, 1);
            n_total++;
            if (obs !== exp_vec())
                $display("FAIL ovf_drain d=%0d: got %h expected %h", d, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (seen != 8 || last != 7)
            $display("FAIL ovf_emitted: got count=%0d last_idx=%0d expected count=8 last_idx=7", seen, last);
        else n_pass++;
    endtask

    task automatic test_resync();
        tick(1, 0, 0, '0, '0, 1);
        tick(0, 1, 0, '0, '0, 1);
        for (int c = 0; c < 20; c++) begin
            tick(0, 0, 1, 16'($urandom), 16'($urandom), c < 17);
            n_total++;
            if (obs !== exp_vec())
                $display("FAIL resync_fill c=%0d: got %h expected %h", c, obs, exp_vec());
            else n_pass++;
        end
        tick(0, 1, 1, 16'($urandom), 16'($urandom), 0);
        tick(0, 0, 1, 16'h0AAA, 16'h0555, 0);
        for (int d = 0; d < 6; d++) begin
            n_total++;
            if (obs !== exp_vec())
                $display("FAIL resync_drain d=%0d: got %h expected %h", d, obs, exp_vec());
            else n_pass++;
            if (bus.OIDX === 6'd19) begin
                n_total++;
                if (bus.OEOF !== 1'b0)
                    $display("FAIL resync_partial_eof: got %b expected 0", bus.OEOF);
                else n_pass++;
            end
            if (d == 4) begin
                n_total++;
                if (bus.OIDX !== 6'd0 || bus.OSOF !== 1'b1 || bus.OR !== 16'h0AAA)
                    $display("FAIL resync_restart: got idx=%0d sof=%b or=%h expected idx=0 sof=1 or=0aaa",
                             bus.OIDX, bus.OSOF, bus.OR);
                else n_pass++;
            end
            tick(0, 0, 0, '0, '0, 1);
        end
    endtask

    task automatic test_rst_mid();
        tick(1, 0, 0, '0, '0, 0);
        tick(0, 1, 0, '0, '0, 0);
        for (int c = 0; c < 5; c++)
            tick(0, 0, 1, 16'($urandom), 16'($urandom), 0);
        n_total++;
        if (bus.OVALID !== 1'b1)
            $display("FAIL rst_mid_queued: got ovalid=%b expected 1", bus.OVALID);
        else n_pass++;
        tick(1, 1, 1, 16'h7777, 16'h8888, 0);
        for (int c = 0; c < 6; c++) begin
            n_total++;
            if (bus.OVALID !== 1'b0 || obs !== exp_vec())
                $display("FAIL rst_mid_idle c=%0d: got %h expected %h", c, obs, exp_vec());
            else n_pass++;
            tick(0, 0, 1, 16'($urandom), 16'($urandom), 1);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        tick(1, 0, 0, '0, '0, 0);
        for (int c = 0; c < 800; c++) begin
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                 16'($urandom), 16'($urandom), $urandom_range(0, 9) < 6);
            n_total++;
            if (obs !== exp_vec()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_model c=%0d: got %h expected %h", c, obs, exp_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        RST = 1'b1; ED = 1'b0; RDY = 1'b0; DR = '0; DI = '0; bus.OREADY = 1'b0;
        test_reset();
        test_no_rdy();
        test_frame();
        test_wrap();
        test_overflow();
        test_resync();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft64_strm_out.md
FFT64_STRM_OUT -- requirements
Module: fft64_strm_out

Interface
REQ-001 Parameter: nb, default 16, width of each real/imaginary sample word.
REQ-002 Parameter: FIFO_AW, default 3, FIFO address width (depth DEPTH = 2**FIFO_AW = 8).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 ED  input  1  upstream data-enable; a sample is presented on DR/DI in every cycle with ED=1.
REQ-006 RDY  input  1  one-cycle pulse from the upstream 64-point buffer marking the start of a frame.
REQ-007 DR, DI  input  nb  upstream real/imaginary sample.
REQ-008 ED_REQ  output  1  flow-control request back to upstream ED generator; 1 = room available.
REQ-009 OVALID  output  1  output sample valid.
REQ-010 OREADY  input  1  downstream accepts the output sample.
REQ-011 OR, OI  output  nb  output real/imaginary sample.
REQ-012 OIDX  output  6  in-frame sample index 0..63.
REQ-013 OSOF, OEOF  output  1  first (OIDX=0) / last (OIDX=63) sample of frame.
REQ-014 OVF  output  1  sticky overflow flag; present only with FFT64_OVF_DET_EN.

Function
REQ-015 Two states: IDLE (after reset, captures ignored) and RUN.
REQ-016 IDLE -> RUN on a cycle with RDY=1; RUN -> IDLE only on RST.
REQ-017 A capture is a cycle with ED=1, RDY=0, state RUN (or the state entered at that edge is RUN from a prior cycle); the RDY cycle itself never captures.
REQ-018 RDY clears the 6-bit index counter to 0; each capture stores {DR, DI, idx, idx==0, idx==63} then increments idx modulo 64 (63 wraps to 0, next frame starts without a new RDY).
REQ-019 RDY received in RUN mid-frame resynchronises: next capture gets idx 0; entries already in FIFO are kept unchanged (partial frame has no OEOF).
REQ-020 FIFO is first-word-fall-through, DEPTH entries; OVALID = FIFO not empty; pop on OVALID & OREADY.
REQ-021 Capture at edge k makes the entry visible with OVALID=1 in cycle k+1 when FIFO was empty (latency 1).
REQ-022 Push is accepted when count < DEPTH, or count == DEPTH with a pop in the same cycle; simultaneous push and pop leave count unchanged.
REQ-023 Capture with count == DEPTH and no pop is dropped; FIFO contents and idx progression unaffected (idx still increments).
REQ-024 ED_REQ is registered: next-cycle value is 1 iff next count <= DEPTH-3, giving two cycles of margin for upstream ED latency.
REQ-025 While OVALID=0, OR, OI, OIDX, OSOF, OEOF are driven 0.
REQ-026 OR/OI/OIDX/OSOF/OEOF are held stable while OVALID=1 and OREADY=0.

Reset
REQ-027 RST has priority over all inputs, including simultaneous RDY and ED.
REQ-028 After RST: state IDLE, idx=0, FIFO empty, OVALID=0, OR=OI=0, OIDX=0, OSOF=OEOF=0, ED_REQ=1, OVF=0.
REQ-029 RST mid-frame discards all FIFO contents; next frame requires a new RDY.

Configuration
REQ-030 Macro FFT64_OVF_DET_EN defined: OVF port exists; it is set in the cycle after a dropped capture (REQ-023) and holds 1 until RST.
REQ-031 Macro FFT64_OVF_DET_EN undefined: OVF port and its logic are absent; drops remain silent; all other behaviour identical.

Verification
REQ-032 Reset, then ED=1 for 10 cycles without RDY, OREADY=1 -> OVALID stays 0, ED_REQ=1.
REQ-033 RDY pulse, then 64 ED cycles with DR=n, DI=-n, OREADY=1 -> 64 outputs in order, OIDX 0..63, OSOF only at n=0, OEOF only at n=63, each one cycle after its capture.
REQ-034 130 continuous ED cycles after one RDY -> OIDX wraps 63->0; second frame OSOF at capture 64, third at capture 128.
REQ-035 OREADY=0, 8 captures -> OVALID=1, count 8, ED_REQ=0 from the cycle after the 6th capture; 9th capture dropped, OVF=1 (macro on); then OREADY=1 -> 8 entries OIDX 0..7 emitted, no 8.
REQ-036 RDY after 20 captures -> next capture emerges with OIDX=0, OSOF=1; sample OIDX=19 has OEOF=0.
REQ-037 RST asserted with 5 entries queued and RDY=1 same cycle -> next cycle OVALID=0, state IDLE, subsequent ED captures ignored.
